many_functions_sched: RTL and testbench

- Round-robin scheduler that shares one instance of the multi-function datapath (arith, bool, shift-case, max-of-3, bit-reverse, mixed) among NREQ requesters.
- Each requester issues an opcode plus operands over a valid/ready handshake. The block arbitrates, latches the operands, computes, and returns a registered result tagged with the requester index under response backpressure.
- Sits between client blocks and the function datapath, replacing per-client copies of the logic.

---
 rtl/many_functions_sched_pkg.sv | 77 +++++++
 rtl/many_functions_sched_if.sv | 30 +++
 rtl/many_functions_sched_alu.sv | 31 +++
 rtl/many_functions_sched.sv | 110 +++++++++++
 tb/tb_many_functions_sched.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/many_functions_sched_pkg.sv
// Shared types and per-opcode functions for the many_functions scheduler.
// Functions work on a wide word and take the live width as an argument.
package many_functions_sched_pkg;

  localparam int MAXW = 64;
  typedef logic [MAXW-1:0] word_t;

  typedef enum logic [2:0] {
    OP_ARITH, OP_BOOL, OP_SHIFT, OP_MAX3, OP_REV, OP_MIXED, OP_ILL6, OP_ILL7
  } op_e;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_e;

  function automatic word_t width_mask(input int w);
    return (w >= MAXW) ? '1 : ((word_t'(1) << w) - word_t'(1));
  endfunction

  function automatic word_t f_arith(input word_t a, input word_t b, input word_t c, input int w);
    word_t t;
    t = ((a + b - c) << 1) | (a & b);
    return (t ^ c) & width_mask(w);
  endfunction

  function automatic word_t f_bool(input word_t a, input word_t b, input logic [1:0] sel, input int w);
    word_t r;
    case (sel)
      2'd0:    r = a & b;
      2'd1:    r = a | b;
      2'd2:    r = a ^ b;
      default: r = ~(a & b);
    endcase
    return r & width_mask(w);
  endfunction

  function automatic word_t f_shift(input word_t a, input logic [1:0] sel, input int w);
    return (a << sel) & width_mask(w);
  endfunction

  function automatic word_t f_max3(input word_t a, input word_t b, input word_t c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction

  function automatic word_t f_rev(input word_t a, input int w);
    word_t r;
    r = '0;
    for (int i = 0; i < MAXW; i++)
      if (i < w) r[i] = a[w-1-i];
    return r;
  endfunction

  function automatic word_t f_mixed(input word_t a, input word_t b, input logic [1:0] sel,
                                    input int w, input int depth);
    word_t r;
    r = '0;
    case (sel)
      2'd0: r = a + b;
      2'd1: begin
        for (int i = 0; i < MAXW / 2; i++)
          if (i < w / 2) begin
            r[2*i]   = a[i];
            r[2*i+1] = b[i];
          end
      end
      2'd2: r = a[w-1] ? (b >> 1) : (a << 1);
      default: begin
        if (a > b) begin
          for (int i = 0; i < MAXW; i++)
            if (i < depth) r = r + (a >> i);
        end else begin
          r = b & width_mask(w) & ~width_mask(w / 2);
        end
      end
    endcase
    return r & width_mask(w);
  endfunction

endpackage

// File: rtl/many_functions_sched_if.sv
// Request/response bus between the requesters and the shared scheduler.
interface many_functions_sched_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  localparam int TAGW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*3-1:0]     req_op;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*WIDTH-1:0] req_c;
  logic [NREQ*2-1:0]     req_sel;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_data;
  logic [TAGW-1:0]       rsp_tag;
  logic                  rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, req_c, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_c, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err
  );
endinterface

// File: rtl/many_functions_sched_alu.sv
// Combinational multi-function datapath shared by all requesters.
module mf_alu
  import many_functions_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  op_e              op,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] data,
  output logic             err
);

  always_comb begin
    data = '0;
    err  = 1'b0;
    case (op)
      OP_ARITH: data = WIDTH'(f_arith(word_t'(a), word_t'(b), word_t'(c), WIDTH));
      OP_BOOL:  data = WIDTH'(f_bool(word_t'(a), word_t'(b), sel, WIDTH));
      OP_SHIFT: data = WIDTH'(f_shift(word_t'(a), sel, WIDTH));
      OP_MAX3:  data = WIDTH'(f_max3(word_t'(a), word_t'(b), word_t'(c)));
      OP_REV:   data = WIDTH'(f_rev(word_t'(a), WIDTH));
      OP_MIXED: data = WIDTH'(f_mixed(word_t'(a), word_t'(b), sel, WIDTH, DEPTH));
      default:  err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/many_functions_sched.sv
// Round-robin scheduler sharing one mf_alu among NREQ requesters;
// each accepted request yields one tagged, registered response.
module many_functions_sched
  import many_functions_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int NREQ  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  many_functions_sched_if.slave   bus,
  output logic                    busy
);

  localparam int TAGW = $clog2(NREQ);

  state_e            state, state_nx;
  logic [TAGW-1:0]   rr_ptr, gnt_idx, lat_idx, rsp_tag_q;
  logic              gnt_found, can_grant, gnt;
  logic [NREQ-1:0]   ready_vec;
  op_e               lat_op;
  logic [1:0]        lat_sel;
  logic [WIDTH-1:0]  lat_a, lat_b, lat_c, alu_data, rsp_data_q;
  logic              alu_err, rsp_err_q;

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_found && bus.req_valid[(int'(rr_ptr) + k) % NREQ]) begin
        gnt_found = 1'b1;
        gnt_idx   = TAGW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  assign can_grant = rst_n && ((state == IDLE) || ((state == RESP) && bus.rsp_ready));
  assign gnt       = can_grant && gnt_found;

  always_comb begin
    ready_vec = '0;
    if (gnt) ready_vec[gnt_idx] = 1'b1;
  end

  assign bus.req_ready = ready_vec;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_tag   = rsp_tag_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (gnt) state_nx = CALC;
      CALC:    state_nx = RESP;
      RESP:    if (bus.rsp_ready) state_nx = gnt ? CALC : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  mf_alu #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_alu (
    .op   (lat_op),
    .sel  (lat_sel),
    .a    (lat_a),
    .b    (lat_b),
    .c    (lat_c),
    .data (alu_data),
    .err  (alu_err)
  );

  // Response registers only load in CALC, so they hold steady under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      lat_idx    <= '0;
      lat_op     <= OP_ARITH;
      lat_sel    <= '0;
      lat_a      <= '0;
      lat_b      <= '0;
      lat_c      <= '0;
      rsp_data_q <= '0;
      rsp_tag_q  <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (gnt) begin
        lat_idx <= gnt_idx;
        lat_op  <= op_e'(bus.req_op[3*int'(gnt_idx) +: 3]);
        lat_sel <= bus.req_sel[2*int'(gnt_idx) +: 2];
        lat_a   <= bus.req_a[WIDTH*int'(gnt_idx) +: WIDTH];
        lat_b   <= bus.req_b[WIDTH*int'(gnt_idx) +: WIDTH];
        lat_c   <= bus.req_c[WIDTH*int'(gnt_idx) +: WIDTH];
        rr_ptr  <= (gnt_idx == TAGW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      end
      if (state == CALC) begin
        rsp_data_q <= alu_data;
        rsp_tag_q  <= lat_idx;
        rsp_err_q  <= alu_err;
      end
    end
  end

endmodule

// File: tb/tb_many_functions_sched.sv
// Directed bench for many_functions_sched: arbitration order, op results,
// backpressure, illegal opcodes and asynchronous reset mid-operation.
module tb_many_functions_sched;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  many_functions_sched_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bif ();

  many_functions_sched #(.WIDTH(WIDTH), .DEPTH(4), .NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input logic [2:0] op, input logic [1:0] sel,
                               input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    bif.req_valid[idx]          = 1'b1;
    bif.req_op[3*idx +: 3]      = op;
    bif.req_sel[2*idx +: 2]     = sel;
    bif.req_a[WIDTH*idx +: WIDTH] = a;
    bif.req_b[WIDTH*idx +: WIDTH] = b;
    bif.req_c[WIDTH*idx +: WIDTH] = c;
    #1;
  endtask

  task automatic clearRequests();
    bif.req_valid = '0;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", name, observed, expected);
    end
  endtask

  task automatic checkResponse(input string name, input logic [7:0] data, input logic [1:0] tag,
                               input logic err);
    checkOutput({name, " rsp_valid"}, 32'(bif.rsp_valid), 32'd1);
    checkOutput({name, " rsp_data"},  32'(bif.rsp_data),  32'(data));
    checkOutput({name, " rsp_tag"},   32'(bif.rsp_tag),   32'(tag));
    checkOutput({name, " rsp_err"},   32'(bif.rsp_err),   32'(err));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] rr_exp [4];
    rr_exp = '{8'h80, 8'h09, 8'hF0, 8'h55};

    bif.req_valid = '0;
    bif.req_op    = '0;
    bif.req_sel   = '0;
    bif.req_a     = '0;
    bif.req_b     = '0;
    bif.req_c     = '0;
    bif.rsp_ready = 1'b1;

    // Reset state, with a request pending that must not be granted
    bif.req_valid[0] = 1'b1;
    tick();
    tick();
    checkOutput("reset req_ready", 32'(bif.req_ready), 32'h0);
    checkOutput("reset rsp_valid", 32'(bif.rsp_valid), 32'h0);
    checkOutput("reset rsp_data",  32'(bif.rsp_data),  32'h0);
    checkOutput("reset rsp_tag",   32'(bif.rsp_tag),   32'h0);
    checkOutput("reset rsp_err",   32'(bif.rsp_err),   32'h0);
    checkOutput("reset busy",      32'(busy),          32'h0);
    clearRequests();
    rst_n = 1'b1;
    tick();

    // All four requesters valid: grants 0,1,2,3,0 with REV/MAX3/MIXED3/MIXED1
    applyStimulus(0, 3'd4, 2'd0, 8'h01, 8'h00, 8'h00);
    applyStimulus(1, 3'd3, 2'd0, 8'h05, 8'h09, 8'h07);
    applyStimulus(2, 3'd5, 2'd3, 8'h80, 8'h10, 8'h00);
    applyStimulus(3, 3'd5, 2'd1, 8'h0F, 8'h00, 8'h00);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("rr grant %0d", k), 32'(bif.req_ready), 32'(1 << (k % 4)));
      tick();
      checkOutput($sformatf("rr calc ready %0d", k), 32'(bif.req_ready), 32'h0);
      checkOutput($sformatf("rr calc valid %0d", k), 32'(bif.rsp_valid), 32'h0);
      tick();
      checkResponse($sformatf("rr rsp %0d", k), rr_exp[k % 4], 2'(k % 4), 1'b0);
    end
    clearRequests();
    tick();
    checkOutput("rr idle busy", 32'(busy), 32'h0);

    // Single ARITH from req0 (pointer at 1, wraps to 0): 0x0E two cycles after handshake
    applyStimulus(0, 3'd0, 2'd0, 8'h03, 8'h05, 8'h01);
    checkOutput("single grant", 32'(bif.req_ready), 32'h1);
    tick();
    clearRequests();
    checkOutput("single calc busy",  32'(busy),          32'h1);
    checkOutput("single calc valid", 32'(bif.rsp_valid), 32'h0);
    tick();
    checkResponse("single arith", 8'h0E, 2'd0, 1'b0);
    tick();
    checkOutput("single idle busy", 32'(busy), 32'h0);

    // Backpressure: BOOL nand from req1 held for 5 cycles while req3 waits
    bif.rsp_ready = 1'b0;
    applyStimulus(1, 3'd1, 2'd3, 8'hFF, 8'h0F, 8'h00);
    checkOutput("bp grant", 32'(bif.req_ready), 32'h2);
    tick();
    clearRequests();
    applyStimulus(3, 3'd0, 2'd0, 8'h03, 8'h05, 8'h01);
    tick();
    for (int k = 0; k < 5; k++) begin
      checkResponse($sformatf("bp hold %0d", k), 8'hF0, 2'd1, 1'b0);
      checkOutput($sformatf("bp ready %0d", k), 32'(bif.req_ready), 32'h0);
      tick();
    end
    bif.rsp_ready = 1'b1;
    #1;
    checkOutput("bp release grant", 32'(bif.req_ready), 32'h8);
    tick();
    clearRequests();
    checkOutput("bp calc valid", 32'(bif.rsp_valid), 32'h0);
    tick();
    checkResponse("bp next", 8'h0E, 2'd3, 1'b0);

    // Illegal op 7 from req2, then legal ops clear the error flag
    applyStimulus(2, 3'd7, 2'd0, 8'hAA, 8'h55, 8'h00);
    checkOutput("ill grant", 32'(bif.req_ready), 32'h4);
    tick();
    clearRequests();
    tick();
    checkResponse("illegal op", 8'h00, 2'd2, 1'b1);
    applyStimulus(1, 3'd5, 2'd0, 8'h20, 8'h30, 8'h00);
    checkOutput("mixed0 grant", 32'(bif.req_ready), 32'h2);
    tick();
    clearRequests();
    tick();
    checkResponse("mixed sel0", 8'h50, 2'd1, 1'b0);
    applyStimulus(2, 3'd2, 2'd2, 8'h21, 8'h00, 8'h00);
    checkOutput("shift grant", 32'(bif.req_ready), 32'h4);
    tick();
    clearRequests();
    tick();
    checkResponse("shift", 8'h84, 2'd2, 1'b0);
    applyStimulus(3, 3'd5, 2'd2, 8'h81, 8'h40, 8'h00);
    checkOutput("mixed2 grant", 32'(bif.req_ready), 32'h8);
    tick();
    clearRequests();
    tick();
    checkResponse("mixed sel2", 8'h20, 2'd3, 1'b0);
    tick();

    // Reset asserted during CALC discards the request and restarts arbitration
    applyStimulus(1, 3'd0, 2'd0, 8'h03, 8'h05, 8'h01);
    checkOutput("rst grant", 32'(bif.req_ready), 32'h2);
    tick();
    clearRequests();
    checkOutput("rst calc busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst busy",      32'(busy),          32'h0);
    checkOutput("rst rsp_valid", 32'(bif.rsp_valid), 32'h0);
    checkOutput("rst rsp_data",  32'(bif.rsp_data),  32'h0);
    checkOutput("rst rsp_tag",   32'(bif.rsp_tag),   32'h0);
    checkOutput("rst req_ready", 32'(bif.req_ready), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput($sformatf("post-rst rsp_valid %0d", k), 32'(bif.rsp_valid), 32'h0);
    end
    bif.req_valid = '1;
    #1;
    checkOutput("post-rst grant", 32'(bif.req_ready), 32'h1);
    clearRequests();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
